// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 UART transmitter
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          txd
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            line_q, line_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic            push, pop, bit_done;

    // Ready looks only at the registered level, so a full queue stays closed in its pop cycle.
    assign wr_ready = (level_q < DEPTH_L);
    assign push     = wr_valid && wr_ready;
    assign bit_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        if (state_q != IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CW'(1);
        end
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line lags the state by one register stage; line_q covers that trailing stop-bit cycle.
    always_comb begin
        txd_d  = 1'b1;
        line_d = (state_q != IDLE);
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[idx_q];
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            line_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            line_q   <= line_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign level = level_q;
    assign txd   = txd_q;
    assign busy  = (state_q != IDLE) || (level_q != '0) || line_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo at CLKS_PER_BIT=4 and at defaults
module tb_uart_tx_fifo;

    localparam int CPB_A = 4;
    localparam int CPB_B = 104;

    logic       clk = 1'b0;
    logic       reset_a = 1'b1, reset_b = 1'b1;
    logic [7:0] wr_data_a = 8'h00, wr_data_b = 8'h00;
    logic       wr_valid_a = 1'b0, wr_valid_b = 1'b0;
    logic       wr_ready_a, wr_ready_b, busy_a, busy_b, txd_a, txd_b;
    logic [2:0] level_a, level_b;

    uart_tx_fifo #(.CLK_FREQ_HZ(16), .BAUD(4), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset_a), .wr_data(wr_data_a), .wr_valid(wr_valid_a),
        .wr_ready(wr_ready_a), .busy(busy_a), .level(level_a), .txd(txd_a)
    );

    uart_tx_fifo dut_b (
        .clk(clk), .reset(reset_b), .wr_data(wr_data_b), .wr_valid(wr_valid_b),
        .wr_ready(wr_ready_b), .busy(busy_b), .level(level_b), .txd(txd_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int start_q[$];

    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh = 8'h00;
    int         frame_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder for dut_a: samples mid-bit, pushes each received byte to got_q.
    always @(negedge clk) begin
        if (reset_a) begin
            mon_act <= 1'b0;
        end else if (!mon_act) begin
            if (txd_a === 1'b0) begin
                mon_act <= 1'b1;
                mon_cnt <= 1;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt % CPB_A == CPB_A / 2) begin
                if (mon_cnt / CPB_A == 0) begin
                    if (txd_a !== 1'b0) frame_err <= frame_err + 1;
                end else if (mon_cnt / CPB_A <= 8) begin
                    mon_sh <= {txd_a, mon_sh[7:1]};
                end else if (txd_a !== 1'b1) begin
                    frame_err <= frame_err + 1;
                end
            end
            if (mon_cnt == 10 * CPB_A - 1) begin
                mon_act <= 1'b0;
                got_q.push_back(mon_sh);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int n, input int limit, output bit ok);
        for (int i = 0; i < limit; i++) begin
            if (got_q.size() >= n) break;
            tick();
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset;
        reset_a = 1'b1;
        reset_b = 1'b1;
        tick();
        reset_a = 1'b0;
        reset_b = 1'b0;
        total++; if (txd_a !== 1'b1) begin bad++; $display("FAIL reset_txd_a: got %b want 1", txd_a); end
        total++; if (wr_ready_a !== 1'b1) begin bad++; $display("FAIL reset_ready_a: got %b want 1", wr_ready_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
        total++; if (level_a !== 3'd0) begin bad++; $display("FAIL reset_level_a: got %0d want 0", level_a); end
        total++; if (txd_b !== 1'b1 || busy_b !== 1'b0 || level_b !== 3'd0 || wr_ready_b !== 1'b1) begin
            bad++; $display("FAIL reset_b: got txd=%b busy=%b level=%0d ready=%b want 1 0 0 1", txd_b, busy_b, level_b, wr_ready_b);
        end
        tick();
    endtask

    task automatic test_single;
        bit ok;
        int errs;
        bit e;
        logic [7:0] g, x;
        total++; if (wr_ready_a !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", wr_ready_a); end
        wr_data_a = 8'h55;
        wr_valid_a = 1'b1;
        exp_q.push_back(8'h55);
        tick();
        wr_valid_a = 1'b0;
        total++; if (busy_a !== 1'b1 || level_a !== 3'd1) begin bad++; $display("FAIL single_queued: got busy=%b level=%0d want 1 1", busy_a, level_a); end
        tick();
        total++; if (txd_a !== 1'b1) begin bad++; $display("FAIL single_latency: got txd=%b want 1 at N+1", txd_a); end
        errs = 0;
        for (int i = 0; i < 10 * CPB_A; i++) begin
            tick();
            e = ((i / CPB_A) % 2) != 0;
            if (txd_a !== e) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL single_bits: got %0d wrong cycles want 0", errs); end
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL single_busy_tail: got %b want 1", busy_a); end
        tick();
        total++; if (busy_a !== 1'b0 || txd_a !== 1'b1) begin bad++; $display("FAIL single_busy_fall: got busy=%b txd=%b want 0 1", busy_a, txd_a); end
        wait_rx(1, 50, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL single_rx: got no byte want 55");
        end else begin
            g = got_q.pop_front(); x = exp_q.pop_front();
            if (g !== x) begin bad++; $display("FAIL single_rx: got %h want %h", g, x); end
        end
    endtask

    task automatic test_fill;
        logic [7:0] bytes [6];
        logic [7:0] g, x;
        bit ok, acc;
        int s0, errs;
        bytes = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h81, 8'h7E};
        s0 = start_q.size();
        for (int i = 0; i < 5; i++) begin
            wr_data_a = bytes[i];
            wr_valid_a = 1'b1;
            total++; if (wr_ready_a !== 1'b1) begin bad++; $display("FAIL fill_accept%0d: got ready=%b want 1", i, wr_ready_a); end
            exp_q.push_back(bytes[i]);
            tick();
        end
        wr_data_a = bytes[5];
        total++; if (wr_ready_a !== 1'b0) begin bad++; $display("FAIL fill_full_ready: got %b want 0", wr_ready_a); end
        total++; if (level_a !== 3'd4) begin bad++; $display("FAIL fill_full_level: got %0d want 4", level_a); end
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            if (wr_ready_a === 1'b1) begin
                exp_q.push_back(bytes[5]);
                acc = 1'b1;
            end
            tick();
        end
        wr_valid_a = 1'b0;
        total++; if (!acc) begin bad++; $display("FAIL fill_late_accept: got no accept want 7e accepted"); end
        wait_rx(6, 400, ok);
        for (int k = 0; k < 6; k++) begin
            total++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                bad++; $display("FAIL fill_rx%0d: got nothing want byte", k);
            end else begin
                g = got_q.pop_front(); x = exp_q.pop_front();
                if (g !== x) begin bad++; $display("FAIL fill_rx%0d: got %h want %h", k, g, x); end
            end
        end
        errs = 0;
        if (start_q.size() < s0 + 6) errs = 99;
        else for (int k = 1; k < 6; k++) if (start_q[s0 + k] - start_q[s0 + k - 1] != 10 * CPB_A) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL fill_contiguous: got %0d gaps want 0", errs); end
        for (int i = 0; i < 20 && busy_a === 1'b1; i++) tick();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL fill_idle: got busy=%b want 0", busy_a); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] bytes [3];
        int got_n, st_n, lows;
        bytes = '{8'hA5, 8'h11, 8'h22};
        got_n = got_q.size();
        for (int i = 0; i < 3; i++) begin
            wr_data_a = bytes[i];
            wr_valid_a = 1'b1;
            exp_q.push_back(bytes[i]);
            tick();
        end
        wr_valid_a = 1'b0;
        repeat (17) tick();
        total++; if (txd_a !== 1'b0 || level_a !== 3'd2) begin bad++; $display("FAIL mid_bit3: got txd=%b level=%0d want 0 2", txd_a, level_a); end
        reset_a = 1'b1;
        wr_data_a = 8'h99;
        wr_valid_a = 1'b1;
        tick();
        reset_a = 1'b0;
        wr_valid_a = 1'b0;
        total++; if (txd_a !== 1'b1) begin bad++; $display("FAIL mid_txd: got %b want 1", txd_a); end
        total++; if (level_a !== 3'd0) begin bad++; $display("FAIL mid_level: got %0d want 0", level_a); end
        total++; if (busy_a !== 1'b0 || wr_ready_a !== 1'b1) begin bad++; $display("FAIL mid_busy: got busy=%b ready=%b want 0 1", busy_a, wr_ready_a); end
        exp_q.delete();
        st_n = start_q.size();
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (txd_a !== 1'b1) lows++;
        end
        total++; if (lows != 0 || start_q.size() != st_n) begin bad++; $display("FAIL mid_silent: got %0d low cycles want 0", lows); end
        total++; if (got_q.size() != got_n) begin bad++; $display("FAIL mid_no_rx: got %0d bytes want %0d", got_q.size(), got_n); end
    endtask

    task automatic test_wrap;
        logic [7:0] g, x;
        bit ok, acc;
        int lvl_err, gap, got0;
        lvl_err = 0;
        got0 = got_q.size();
        for (int i = 0; i < 20; i++) begin
            gap = $urandom_range(0, 3);
            wr_valid_a = 1'b0;
            for (int j = 0; j < gap; j++) begin
                tick();
                if (level_a > 3'd4) lvl_err++;
            end
            wr_data_a = 8'($urandom);
            wr_valid_a = 1'b1;
            acc = 1'b0;
            for (int j = 0; j < 200 && !acc; j++) begin
                if (wr_ready_a === 1'b1) begin
                    exp_q.push_back(wr_data_a);
                    acc = 1'b1;
                end
                tick();
                if (level_a > 3'd4) lvl_err++;
            end
            if (!acc) lvl_err += 1000;
        end
        wr_valid_a = 1'b0;
        total++; if (lvl_err != 0) begin bad++; $display("FAIL wrap_level: got %0d bad cycles want 0", lvl_err); end
        wait_rx(got0 + 20, 1500, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_count: got %0d bytes want %0d", got_q.size() - got0, 20); end
        for (int k = 0; k < 20; k++) begin
            total++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                bad++; $display("FAIL wrap_rx%0d: got nothing want byte", k);
            end else begin
                g = got_q.pop_front(); x = exp_q.pop_front();
                if (g !== x) begin bad++; $display("FAIL wrap_rx%0d: got %h want %h", k, g, x); end
            end
        end
        total++; if (frame_err != 0) begin bad++; $display("FAIL framing: got %0d errors want 0", frame_err); end
    endtask

    task automatic test_default;
        int errs;
        bit e;
        wr_data_b = 8'h80;
        wr_valid_b = 1'b1;
        tick();
        wr_valid_b = 1'b0;
        tick();
        total++; if (txd_b !== 1'b1) begin bad++; $display("FAIL dflt_latency: got %b want 1", txd_b); end
        errs = 0;
        for (int i = 0; i < 10 * CPB_B; i++) begin
            tick();
            e = (i / CPB_B) >= 8;
            if (txd_b !== e) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL dflt_bits: got %0d wrong cycles want 0", errs); end
        total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL dflt_busy_tail: got %b want 1", busy_b); end
        tick();
        total++; if (busy_b !== 1'b0 || txd_b !== 1'b1) begin bad++; $display("FAIL dflt_idle: got busy=%b txd=%b want 0 1", busy_b, txd_b); end
    endtask

    initial begin
        test_reset();
        test_single();
        tick();
        test_fill();
        test_reset_mid();
        test_wrap();
        test_default();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
